// File: rtl/dc_restore.sv
// dc_restore: inverse of a first-order DC reject filter,
//   x(n) = x(n-1) + y(n) - alpha*y(n-1)
// computed at ALPHA_WIDTH precision by a four-state sequencer (one sample per 4 cycles).
// Build option: define DC_RESTORE_SAT_EN to clamp accumulator overflow and raise a sticky
// sat_flag; without it the accumulator wraps and sat_flag stays 0.
//
// state | meaning
// IDLE  | in_ready high, waiting for a sample; captures in and alpha on in_valid
// MUL   | registers the feedback term y_ext(n-1)*alpha
// ACC   | updates accumulator, out and the y history
// OUT   | out_valid high, out held until out_ready
module dc_restore #(
    parameter int SIGNAL_WIDTH = 16,
    parameter int ALPHA_WIDTH  = 24
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic [ALPHA_WIDTH-1:0]  alpha,
    input  logic [SIGNAL_WIDTH-1:0] in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [SIGNAL_WIDTH-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag
);

    localparam int AW = ALPHA_WIDTH;
    localparam int SW = SIGNAL_WIDTH;
    localparam int SH = AW - SW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]   y_cur_q;
    logic [AW-1:0]   y_hist_q;
    logic [AW-1:0]   alpha_q;
    logic [AW-1:0]   fb_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [SW-1:0]   out_q;
    logic [2*AW-1:0] prod;
    logic [AW+1:0]   acc_sum;
    logic            prod_unused;

    // Sequencer state register
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: state_d = S_ACC;
            S_ACC: state_d = S_OUT;
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Full signed product; both operands sign-extended so the 2*AW result is exact.
    assign prod = $signed({{AW{y_hist_q[AW-1]}}, y_hist_q}) *
                  $signed({{AW{alpha_q[AW-1]}}, alpha_q});

    // Only the Q1.(AW-1)-aligned slice of the product feeds back.
    assign prod_unused = ^{prod[2*AW-1], prod[AW-2:0]};

    // Two guard bits so that overflow of x(n-1) + y(n) - fb is always detectable.
    assign acc_sum = {{2{acc_q[AW-1]}}, acc_q}
                   + {{2{y_cur_q[AW-1]}}, y_cur_q}
                   - {{2{fb_q[AW-1]}}, fb_q};

`ifdef DC_RESTORE_SAT_EN
    logic sat_hit;
    logic sat_q;

    // Clamp to the AW-bit signed range when the guard bits disagree with the sign
    always_comb begin
        acc_d   = acc_sum[AW-1:0];
        sat_hit = 1'b0;
        if ((acc_sum[AW+1:AW-1] != 3'b000) && (acc_sum[AW+1:AW-1] != 3'b111)) begin
            sat_hit = 1'b1;
            acc_d   = acc_sum[AW+1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end
    end

    // Sticky saturation indicator, cleared only by reset
    always_ff @(posedge aclk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if ((state_q == S_ACC) && sat_hit) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic sum_unused;

    // Two's-complement wrap: keep the low AW bits
    always_comb begin
        acc_d = acc_sum[AW-1:0];
    end

    assign sum_unused = ^acc_sum[AW+1:AW];
    assign sat_flag   = 1'b0;
`endif

    // Datapath registers, each advanced only in its own sequencer state
    always_ff @(posedge aclk) begin
        if (reset) begin
            y_cur_q  <= '0;
            y_hist_q <= '0;
            alpha_q  <= '0;
            fb_q     <= '0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        y_cur_q <= {in, {SH{1'b0}}};
                        alpha_q <= alpha;
                    end
                end
                S_MUL: fb_q <= prod[2*AW-2:AW-1];
                S_ACC: begin
                    acc_q    <= acc_d;
                    out_q    <= acc_d[AW-1:SH];
                    y_hist_q <= y_cur_q;
                end
                default: ;
            endcase
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dc_restore.sv
// Bench for dc_restore: integer reference model of x(n) = x(n-1) + y(n) - alpha*y(n-1),
// per-cycle handshake/output compare, directed literal cases and a randomized phase.
module tb_dc_restore;

    localparam int SW = 16;
    localparam int AW = 24;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic          aclk      = 1'b0;
    logic          reset     = 1'b1;
    logic [AW-1:0] alpha     = '0;
    logic [SW-1:0] din       = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [SW-1:0] dout;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          sat_flag;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    dc_restore #(.SIGNAL_WIDTH(SW), .ALPHA_WIDTH(AW)) dut (
        .aclk      (aclk),
        .reset     (reset),
        .alpha     (alpha),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag)
    );

    typedef struct {
        logic [SW-1:0] o;
        bit            s;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] got_q[$];
    longint        m_acc   = 0;
    longint        m_yprev = 0;
    bit            m_sat   = 0;
    bit            exp_sat = 0;
    bit            in_flight = 0;
    bit            started = 0;
    bit            rdy_rand = 0;
    int            cyc = 0;
    int            acc_cyc = 0;

    task automatic chk(bit cond, string name, longint act, longint req);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint wrapw(longint v, int w);
        longint m = longint'(1) << w;
        longint r = v & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    // Reference: one accepted sample through the restore equation in plain integers.
    function automatic void model_accept(logic [SW-1:0] y, logic [AW-1:0] a);
        longint ye = longint'($signed(y)) * 256;
        longint al = longint'($signed(a));
        longint fb = wrapw((m_yprev * al) >>> (AW - 1), AW);
        longint s  = m_acc + ye - fb;
        exp_t   e;
`ifdef DC_RESTORE_SAT_EN
        if (s > MAXV) begin
            s = MAXV;
            m_sat = 1'b1;
        end else if (s < MINV) begin
            s = MINV;
            m_sat = 1'b1;
        end
`else
        s = wrapw(s, AW);
`endif
        m_acc   = s;
        m_yprev = ye;
        e.o = SW'(s >>> (AW - SW));
        e.s = m_sat;
        exp_q.push_back(e);
    endfunction

    // Compare process: every cycle, away from the active edge
    always @(negedge aclk) begin
        bit idle;
        bit exp_ov;
        cyc++;
        idle   = !in_flight;
        exp_ov = in_flight && ((cyc - acc_cyc) >= 3);
        if (started) begin
            chk(in_ready === idle, "in_ready", longint'(in_ready), longint'(idle));
            chk(out_valid === exp_ov, "out_valid", longint'(out_valid), longint'(exp_ov));
            if (exp_ov && exp_q.size() > 0) begin
                exp_sat = exp_q[0].s;
                chk(dout === exp_q[0].o, "out", longint'(dout), longint'(exp_q[0].o));
            end
            chk(sat_flag === exp_sat, "sat_flag", longint'(sat_flag), longint'(exp_sat));
        end
        if (reset) begin
            exp_q.delete();
            in_flight = 0;
            m_acc     = 0;
            m_yprev   = 0;
            m_sat     = 0;
            exp_sat   = 0;
            started   = 1;
        end else if (started) begin
            if (exp_ov && out_ready) begin
                got_q.push_back(dout);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_flight = 0;
            end
            if (idle && in_valid) begin
                model_accept(din, alpha);
                in_flight = 1;
                acc_cyc   = cyc;
            end
        end
    end

    // Randomized downstream back-pressure when enabled
    always @(posedge aclk) begin
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic send(logic [SW-1:0] y, logic [AW-1:0] a);
        int n = 0;
        din      = y;
        alpha    = a;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk(1'b0, "send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        din      = SW'($urandom);
        alpha    = AW'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (in_flight && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk(1'b0, "drain_timeout", 0, 1);
    endtask

    task automatic chk_got(string name, int idx, logic [SW-1:0] v);
        if (idx < got_q.size()) chk(got_q[idx] === v, name, longint'(got_q[idx]), longint'(v));
        else chk(1'b0, name, -1, longint'(v));
    endtask

    initial begin
        longint r;
        longint yq_ext;
        longint fb;
        longint tgt;
        longint yq;
        int     xs[$];
        int     n;
        int     held;

        do_reset();
        chk(in_ready === 1'b1, "reset_in_ready", longint'(in_ready), 1);
        chk(out_valid === 1'b0, "reset_out_valid", longint'(out_valid), 0);
        chk(dout === 16'h0000, "reset_out", longint'(dout), 0);
        chk(sat_flag === 1'b0, "reset_sat", longint'(sat_flag), 0);

        // alpha = 0: pure integrator
        out_ready = 1'b1;
        send(16'h1000, 24'h000000);
        send(16'h0000, 24'h000000);
        send(16'h0000, 24'h000000);
        wait_drain();
        chk_got("a0_s0", 0, 16'h1000);
        chk_got("a0_s1", 1, 16'h1000);
        chk_got("a0_s2", 2, 16'h1000);

        // alpha = 0.5
        do_reset();
        send(16'h1000, 24'h400000);
        send(16'h0000, 24'h400000);
        send(16'h0000, 24'h400000);
        wait_drain();
        chk_got("ahalf_s0", 0, 16'h1000);
        chk_got("ahalf_s1", 1, 16'h0800);
        chk_got("ahalf_s2", 2, 16'h0800);

        // Overflow: clamp or wrap depending on build
        do_reset();
        send(16'h7000, 24'h000000);
        send(16'h7000, 24'h000000);
        wait_drain();
        chk_got("ovf_s0", 0, 16'h7000);
`ifdef DC_RESTORE_SAT_EN
        chk_got("ovf_s1", 1, 16'h7FFF);
        chk(sat_flag === 1'b1, "ovf_sat", longint'(sat_flag), 1);
`else
        chk_got("ovf_s1", 1, 16'hE000);
        chk(sat_flag === 1'b0, "ovf_sat", longint'(sat_flag), 0);
`endif

        // Back-pressure: hold in OUT for 5 cycles with in_valid noise
        do_reset();
        out_ready = 1'b0;
        send(16'h0200, 24'h000000);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        held = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            din      = SW'($urandom);
            alpha    = AW'($urandom);
            tick();
            if (out_valid === 1'b1 && dout === 16'h0200 && in_ready === 1'b0) held++;
        end
        chk(held == 5, "hold_stable", held, 5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk(in_ready === 1'b1, "release_idle", longint'(in_ready), 1);
        chk(got_q.size() == 1, "hold_count", got_q.size(), 1);
        chk_got("hold_val", 0, 16'h0200);

        // Reset while the sample sits in ACC
        do_reset();
        send(16'h1234, 24'h000000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        chk(got_q.size() == 0, "abandoned", got_q.size(), 0);
        send(16'h0100, 24'h000000);
        wait_drain();
        chk_got("after_rst", 0, 16'h0100);

        // Noise-shaped DC reject feeding the restore; reconstruction within +/-2 LSB
        do_reset();
        r = 0;
        yq_ext = 0;
        for (int i = 0; i < 1000; i++) begin
            int x;
            x   = int'(1024.0 + 12288.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 50.0));
            fb  = wrapw((yq_ext * longint'(24'sh7FFE5E)) >>> (AW - 1), AW);
            tgt = longint'(x) * 256 - r + fb;
            yq  = tgt >>> 8;
            yq_ext = yq * 256;
            r   = r + yq_ext - fb;
            xs.push_back(x);
            send(SW'(yq), 24'h7FFE5E);
        end
        wait_drain();
        chk(got_q.size() == 1000, "sine_count", got_q.size(), 1000);
        for (int i = 0; i < 1000 && i < got_q.size(); i++) begin
            int d;
            d = int'($signed(got_q[i])) - xs[i];
            chk(d >= -2 && d <= 2, "sine_recon", longint'($signed(got_q[i])), longint'(xs[i]));
        end

        // Randomized samples, coefficients, back-pressure and occasional resets
        do_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            repeat ($urandom_range(0, 2)) tick();
            case ($urandom_range(0, 3))
                0: a = 24'h000000;
                1: a = AW'($urandom_range(24'h700000, 24'h7FFFFF));
                2: a = AW'($urandom);
                default: a = 24'h400000;
            endcase
            send(SW'($urandom), a);
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end
        rdy_rand  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
